seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream display stage between the CPU debug-value mux and the board's 4-digit common-anode seven-segment display.
- Latches a 16-bit hex value through a load strobe and commits it only at frame boundaries, so a frame never mixes old and new digits.
- Time-multiplexes the four digits with an internal prescaler, so no separate scan clock is needed.
- Decodes each nibble to active-low segments, with optional leading-zero blanking and per-digit decimal points.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (must be ≥2).
- CNT_W, 16, prescaler width (must satisfy 2^CNT_W ≥ SCAN_DIV).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  16  value to display; nibble k maps to digit k, digit 0 is rightmost.
- load  in  1  single-cycle strobe that captures data_in.
- lz_en  in  1  1 = blank leading zero digits.
- dp_mask  in  4  1 = light decimal point of digit k.
- an  out  4  anode enables, active-low; an[k] = digit k.
- caths  out  8  cathodes, active-low; [7]=dp, [6:0]={g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset values (async, immediate, not waiting for an edge):
  - prescaler=0, idx=0, disp=0, pend_val=0, pend=0.
  - an=4'b1111, caths=8'hFF, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick=1 in the cycle prescaler==SCAN_DIV-1.
- Digit index:
  - idx (2 bits) advances on tick; 3 wraps to 0.
- Load and commit:
  - load=1 → pend_val<=data_in, pend<=1. A later load before commit overwrites pend_val (last load wins).
  - Commit happens in a cycle with tick && idx==3 && pend: disp<=pend_val, pend<=0.
  - load in the same cycle as a commit → disp<=data_in directly, pend<=0.
  - load with no commit → data becomes visible starting with the next frame's digit 0, never mid-frame.
- Output register (updated every clk from the current idx and disp):
  - an, caths and frame_done all lag idx by one cycle.
  - Digit k is shown on an[k]=0 for exactly SCAN_DIV cycles per frame.
  - After reset release, the first edge drives an=4'b1110 for digit 0.
- Leading-zero blanking:
  - If lz_en=1 and disp[15:4k]==0 for k in {1,2,3}, digit k is blanked: an=4'b1111 and caths=8'hFF during its slot.
  - Digit 0 is never blanked; value 0 shows a single "0".
- Decimal point:
  - caths[7] = ~dp_mask[k] while digit k is shown.
  - dp is suppressed on blanked digits.
- Hex decode, caths[6:0] for 0–F:
  - 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex).
- frame_done:
  - Asserted for one cycle, concurrent with the first output cycle showing digit 0 of a new frame.
  - Not asserted for the initial post-reset frame.
- Reset mid-frame: outputs go dark immediately and pending data is discarded.
- lz_en and dp_mask are sampled live every cycle; they are not latched per frame.

Test Plan:
1. SCAN_DIV=4, hold reset for 3 clk.
   - During reset: an=1111, caths=FF, with no clk edge needed.
   - After release: an sequence 1110,1101,1011,0111, each slot exactly 4 clk, caths=C0 in every slot.
   - frame_done pulses when digit 0 reappears.
2. load=1 with data_in=16'h12AF while digit 1 is shown.
   - Current frame keeps showing C0.
   - Next frame: digit0=8E, digit1=88, digit2=A4, digit3=F9.
3. lz_en=1:
   - disp=16'h0030: digit3 and digit2 slots show an=1111/caths=FF; digit1=B0, digit0=C0.
   - disp=0: only digit0 lit.
   - disp=16'h0100: digit2=F9, digit1=C0, digit0=C0.
4. dp_mask=4'b0100, disp=16'h8888: caths=00 in the digit2 slot, 80 in all other slots.
5. load collisions:
   - load=16'h1111 then load=16'h2222 within one frame → next frame shows all 2s (A4).
   - load=16'h3333 exactly on the commit cycle (tick, idx=3) → next frame shows 3s (B0), and pend is clear afterwards.
6. Assert reset asynchronously mid-slot with a pending load:
   - an=1111 and caths=FF before the next clk edge.
   - After release the display shows 0s and the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Scans a 16-bit hex value onto a 4-digit common-anode seven-segment display.
// A new value is captured by a load strobe but only committed to the display
// at a frame boundary, so one frame never mixes old and new digits. An
// internal prescaler sets the digit slot length; leading-zero blanking and
// per-digit decimal points are applied live.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   data_in    value to display; nibble k drives digit k (digit 0 rightmost)
//   load       single-cycle strobe capturing data_in
//   lz_en      1 = blank leading zero digits (digit 0 is never blanked)
//   dp_mask    1 = light the decimal point of digit k
//   an         anode enables, active-low, an[k] = digit k
//   caths      cathodes, active-low, [7]=dp, [6:0]={g,f,e,d,c,b,a}
//   frame_done one-cycle pulse with the first output cycle of each new frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int SCAN_DIV = 50000,  // clk cycles per digit slot, >= 2
    parameter int CNT_W    = 16      // 2**CNT_W >= SCAN_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic        lz_en,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [7:0]  caths,
    output logic        frame_done
);

    logic [CNT_W-1:0] prescaler;
    logic [1:0]       idx;
    logic [15:0]      disp;
    logic [15:0]      pend_val;
    logic             pend;
    logic             new_frame;

    logic             tick;
    logic             frame_end;
    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       seg;
    logic [3:0]       an_next;
    logic [7:0]       caths_next;

    assign tick      = (prescaler == CNT_W'(SCAN_DIV - 1));
    // Last cycle of the digit-3 slot: the only point where disp may change.
    assign frame_end = tick && (idx == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= 2'd0;
        end else begin
            prescaler <= tick ? '0 : prescaler + CNT_W'(1);
            if (tick)
                idx <= idx + 2'd1;
        end
    end

    // Load capture and frame-boundary commit. A load coinciding with the
    // boundary goes straight to disp so it is not delayed by a whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp     <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
        end else if (frame_end && load) begin
            disp <= data_in;
            pend <= 1'b0;
        end else if (load) begin
            pend_val <= data_in;
            pend     <= 1'b1;
        end else if (frame_end && pend) begin
            disp <= pend_val;
            pend <= 1'b0;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        nibble = disp[{idx, 2'b00} +: 4];
        blank  = 1'b0;
        if (lz_en) begin
            unique case (idx)
                2'd1:    blank = (disp[15:4]  == 12'h000);
                2'd2:    blank = (disp[15:8]  == 8'h00);
                2'd3:    blank = (disp[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        seg = 7'h7F;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

    always_comb begin
        an_next    = 4'b1111;
        caths_next = 8'hFF;
        if (!blank) begin
            an_next    = ~(4'b0001 << idx);
            caths_next = {~dp_mask[idx], seg};
        end
    end

    // Registered outputs lag idx by one cycle. new_frame marks the digit-3 to
    // digit-0 wrap, so the first frame after reset never raises frame_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 4'b1111;
            caths      <= 8'hFF;
            frame_done <= 1'b0;
            new_frame  <= 1'b0;
        end else begin
            an         <= an_next;
            caths      <= caths_next;
            frame_done <= new_frame;
            new_frame  <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed frames for seg7_scan_driver with SCAN_DIV=4 (16 clk per frame).
// The stimulus process pushes one expected {an, caths, frame_done} entry per
// output cycle into a queue; the monitor pops one entry on every falling edge
// and compares it with the registered outputs.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [7:0]  caths;
    logic        frame_done;

    typedef struct {
        logic [3:0] an;
        logic [7:0] caths;
        logic       fd;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en;
    int   vectors;
    int   miscompares;

    seg7_scan_driver #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .lz_en      (lz_en),
        .dp_mask    (dp_mask),
        .an         (an),
        .caths      (caths),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int tag,
                         input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s (tag %0d): got %0h, expected %0h", name, tag, actual, expected);
        end
    endtask

    // Monitor: one expected entry per output cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("queue_underrun", -1, 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("an",         e.tag, 32'(an),         32'(e.an));
                    check("caths",      e.tag, 32'(caths),      32'(e.caths));
                    check("frame_done", e.tag, 32'(frame_done), 32'(e.fd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_dark(input int tag);
        check("dark_an",    tag, 32'(an),         32'h0000000F);
        check("dark_caths", tag, 32'(caths),      32'h000000FF);
        check("dark_fd",    tag, 32'(frame_done), 32'd0);
    endtask

    // One display frame. cw = {digit3, digit2, digit1, digit0} expected
    // cathodes; blank[k] marks a dark slot. Loads are issued on cycle offsets
    // la_at / lb_at; abort_at asserts reset asynchronously in that cycle.
    task automatic do_frame(input int tag, input logic [31:0] cw,
                            input logic [3:0] blank, input bit fd,
                            input bit lz, input logic [3:0] dp,
                            input int la_at, input logic [15:0] la_val,
                            input int lb_at, input logic [15:0] lb_val,
                            input int abort_at);
        exp_t e;
        for (int c = 0; c < FRAME; c++) begin
            int k;
            k       = c / SCAN_DIV;
            e.an    = blank[k] ? 4'b1111 : ~(4'b0001 << k);
            e.caths = blank[k] ? 8'hFF : cw[8*k +: 8];
            e.fd    = fd && (c == 0);
            e.tag   = tag * 100 + c;
            exp_q.push_back(e);
        end
        for (int c = 0; c < FRAME; c++) begin
            lz_en   = lz;
            dp_mask = dp;
            load    = 1'b0;
            if (c == la_at) begin
                load    = 1'b1;
                data_in = la_val;
            end else if (c == lb_at) begin
                load    = 1'b1;
                data_in = lb_val;
            end
            if (c == abort_at) begin
                @(posedge clk);
                load = 1'b0;
                #2;
                mon_en = 1'b0;
                reset  = 1'b1;
                #1;
                check_dark(tag * 100 + c);
                exp_q.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                #1;
                mon_en = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        reset       = 1'b0;
        data_in     = '0;
        load        = 1'b0;
        lz_en       = 1'b0;
        dp_mask     = 4'b0000;

        // Reset asserted before any clock edge: outputs must already be dark.
        #1 reset = 1'b1;
        #2 check_dark(1);
        repeat (3) @(posedge clk);
        #1 check_dark(2);
        @(negedge clk);
        reset = 1'b0;
        #1 mon_en = 1'b1;

        // tag, {d3,d2,d1,d0}, blank, fd, lz, dp, loadA, loadB, abort
        // Frame 0: zeros; load 12AF while digit 1 is shown.
        do_frame(10, 32'hC0C0C0C0, 4'b0000, 0, 0, 4'b0000,  5, 16'h12AF, -1, 16'h0, -1);
        // Frame 1: 12AF.
        do_frame(11, 32'hF9A4888E, 4'b0000, 1, 0, 4'b0000,  3, 16'h0030, -1, 16'h0, -1);
        // Leading-zero blanking on 0030, 0000, 0100.
        do_frame(12, 32'hFFFFB0C0, 4'b1100, 1, 1, 4'b0000,  0, 16'h0000, -1, 16'h0, -1);
        do_frame(13, 32'hFFFFFFC0, 4'b1110, 1, 1, 4'b0000, 15, 16'h0100, -1, 16'h0, -1);
        do_frame(14, 32'hFFF9C0C0, 4'b1000, 1, 1, 4'b0000,  7, 16'h8888, -1, 16'h0, -1);
        // 8888 with dp on digit 2; two loads in one frame, last wins.
        do_frame(15, 32'h80008080, 4'b0000, 1, 0, 4'b0100,  2, 16'h1111,  9, 16'h2222, -1);
        // 2222; pending 4444 then 3333 exactly on the commit cycle.
        do_frame(16, 32'hA4A4A4A4, 4'b0000, 1, 0, 4'b0000,  3, 16'h4444, 15, 16'h3333, -1);
        // 3333 twice: nothing left pending after the collision.
        do_frame(17, 32'hB0B0B0B0, 4'b0000, 1, 0, 4'b0000, -1, 16'h0,    -1, 16'h0, -1);
        do_frame(18, 32'hB0B0B0B0, 4'b0000, 1, 0, 4'b0000, -1, 16'h0,    -1, 16'h0, -1);
        // Pending 5555 then asynchronous reset mid-slot.
        do_frame(19, 32'hB0B0B0B0, 4'b0000, 1, 0, 4'b0000,  2, 16'h5555, -1, 16'h0,  6);
        // After reset: zeros, no frame_done on the first frame, 5555 never shown.
        do_frame(20, 32'hC0C0C0C0, 4'b0000, 0, 0, 4'b0000, -1, 16'h0,    -1, 16'h0, -1);
        do_frame(21, 32'hC0C0C0C0, 4'b0000, 1, 0, 4'b0000, -1, 16'h0,    -1, 16'h0, -1);

        #1;
        mon_en = 1'b0;
        check("queue_drained", 99, 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
